// File: rtl/sad_search.sv
// Block-matching SAD search: sums |A-B| over each candidate block,
// writes every per-candidate SAD and reports the minimum and its index.
module sad_search #(
  parameter int D_WIDTH   = 8,
  parameter int A_WIDTH   = 15,
  parameter int BLK_LEN   = 256,
  parameter int NUM_CAND  = 4,
  parameter int SAD_WIDTH = 32,
  localparam int IDX_W    = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Go,
  output logic [A_WIDTH-1:0]   A_Addr,
  output logic                 A_En,
  input  logic [D_WIDTH-1:0]   A_Data,
  output logic [A_WIDTH-1:0]   B_Addr,
  output logic                 B_En,
  input  logic [D_WIDTH-1:0]   B_Data,
  output logic [IDX_W-1:0]     C_Addr,
  output logic [SAD_WIDTH-1:0] C_Data,
  output logic                 C_We,
  output logic                 Busy,
  output logic                 Done,
  output logic [SAD_WIDTH-1:0] SAD_Out,
  output logic [IDX_W-1:0]     Min_Idx
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_DRAIN, S_STORE, S_DONE
  } state_t;

  localparam int XW = ((SAD_WIDTH > D_WIDTH) ? SAD_WIDTH : D_WIDTH) + 1;
  localparam logic [A_WIDTH-1:0] I_LAST = A_WIDTH'(BLK_LEN - 1);
  localparam logic [IDX_W-1:0]   K_LAST = IDX_W'(NUM_CAND - 1);
  localparam logic [XW-1:0]      SAT    = XW'({SAD_WIDTH{1'b1}});

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       k_q, k_d;
  logic [SAD_WIDTH-1:0]   acc_q, acc_d;
  logic [SAD_WIDTH-1:0]   min_q, min_d;
  logic [IDX_W-1:0]       midx_q, midx_d;
  logic [A_WIDTH-1:0]     a_addr_q, a_addr_d;
  logic [A_WIDTH-1:0]     b_addr_q, b_addr_d;
  logic                   en_q, en_d;
  logic [IDX_W-1:0]       c_addr_q, c_addr_d;
  logic [SAD_WIDTH-1:0]   c_data_q, c_data_d;
  logic                   c_we_q, c_we_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [SAD_WIDTH-1:0]   sad_q, sad_d;
  logic [IDX_W-1:0]       idx_q, idx_d;

  logic [D_WIDTH-1:0]     diff;
  logic [XW-1:0]          sum_x;
  logic [SAD_WIDTH-1:0]   acc_add;
  logic                   lt;

  always_comb begin
    diff = (A_Data > B_Data) ? (A_Data - B_Data) : (B_Data - A_Data);
    sum_x = XW'(acc_q) + XW'(diff);
    // Saturate instead of wrapping so a huge SAD never looks small.
    acc_add = (sum_x > SAT) ? {SAD_WIDTH{1'b1}} : sum_x[SAD_WIDTH-1:0];
    lt = acc_q < min_q;
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    acc_d    = acc_q;
    min_d    = min_q;
    midx_d   = midx_q;
    a_addr_d = a_addr_q;
    b_addr_d = b_addr_q;
    c_addr_d = c_addr_q;
    c_data_d = c_data_q;
    sad_d    = sad_q;
    idx_d    = idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (Go) begin
          state_d  = S_READ;
          k_d      = '0;
          acc_d    = '0;
          min_d    = '1;
          midx_d   = '0;
          a_addr_d = '0;
          b_addr_d = '0;
        end
      end
      S_READ: begin
        if (a_addr_q != '0) acc_d = acc_add;
        if (a_addr_q == I_LAST) begin
          state_d = S_DRAIN;
        end else begin
          a_addr_d = a_addr_q + A_WIDTH'(1);
          b_addr_d = b_addr_q + A_WIDTH'(1);
        end
      end
      S_DRAIN: begin
        acc_d    = acc_add;
        c_data_d = acc_add;
        c_addr_d = k_q;
        state_d  = S_STORE;
      end
      S_STORE: begin
        if (lt) begin
          min_d  = acc_q;
          midx_d = k_q;
        end
        if (k_q == K_LAST) begin
          state_d = S_DONE;
          sad_d   = lt ? acc_q : min_q;
          idx_d   = lt ? k_q : midx_q;
        end else begin
          state_d  = S_READ;
          k_d      = k_q + IDX_W'(1);
          acc_d    = '0;
          a_addr_d = '0;
          b_addr_d = b_addr_q + A_WIDTH'(1);
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    en_d   = (state_d == S_READ);
    c_we_d = (state_d == S_STORE);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      acc_q    <= '0;
      min_q    <= '0;
      midx_q   <= '0;
      a_addr_q <= '0;
      b_addr_q <= '0;
      en_q     <= 1'b0;
      c_addr_q <= '0;
      c_data_q <= '0;
      c_we_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sad_q    <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      min_q    <= min_d;
      midx_q   <= midx_d;
      a_addr_q <= a_addr_d;
      b_addr_q <= b_addr_d;
      en_q     <= en_d;
      c_addr_q <= c_addr_d;
      c_data_q <= c_data_d;
      c_we_q   <= c_we_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sad_q    <= sad_d;
      idx_q    <= idx_d;
    end
  end

  assign A_Addr  = a_addr_q;
  assign A_En    = en_q;
  assign B_Addr  = b_addr_q;
  assign B_En    = en_q;
  assign C_Addr  = c_addr_q;
  assign C_Data  = c_data_q;
  assign C_We    = c_we_q;
  assign Busy    = busy_q;
  assign Done    = done_q;
  assign SAD_Out = sad_q;
  assign Min_Idx = idx_q;

endmodule

// File: tb/tb_sad_search.sv
// Randomized and directed bench for sad_search with a
// behavioural SAD/minimum reference model.
module tb_sad_search;
  localparam int BL = 4;
  localparam int NC = 3;
  localparam int AW = 15;
  localparam int SW = 32;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic go  = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] a_addr, b_addr;
  logic          a_en, b_en;
  logic [7:0]    a_data = '0, b_data = '0;
  logic [IW-1:0] c_addr, min_idx;
  logic [SW-1:0] c_data, sad_out;
  logic          c_we, busy, done;

  logic [7:0] a_mem [BL];
  logic [7:0] b_mem [BL*NC];

  sad_search #(.D_WIDTH(8), .A_WIDTH(AW), .BLK_LEN(BL),
               .NUM_CAND(NC), .SAD_WIDTH(SW)) dut (
    .Clk(clk), .Rst(rst), .Go(go),
    .A_Addr(a_addr), .A_En(a_en), .A_Data(a_data),
    .B_Addr(b_addr), .B_En(b_en), .B_Data(b_data),
    .C_Addr(c_addr), .C_Data(c_data), .C_We(c_we),
    .Busy(busy), .Done(done), .SAD_Out(sad_out), .Min_Idx(min_idx));

  always @(posedge clk) begin
    if (a_en) a_data <= (a_addr < BL) ? a_mem[a_addr[1:0]] : 8'hEE;
    if (b_en) b_data <= (b_addr < BL*NC) ? b_mem[b_addr[3:0]] : 8'hEE;
  end

  // Saturation instance: 4-bit SAD, one candidate
  logic          s_go = 1'b0;
  logic [AW-1:0] s_a_addr, s_b_addr;
  logic          s_a_en, s_b_en;
  logic [7:0]    s_a_data = '0, s_b_data = '0;
  logic [0:0]    s_c_addr, s_min_idx;
  logic [3:0]    s_c_data, s_sad_out;
  logic          s_c_we, s_busy, s_done;

  sad_search #(.D_WIDTH(8), .A_WIDTH(AW), .BLK_LEN(4),
               .NUM_CAND(1), .SAD_WIDTH(4)) dut_sat (
    .Clk(clk), .Rst(rst), .Go(s_go),
    .A_Addr(s_a_addr), .A_En(s_a_en), .A_Data(s_a_data),
    .B_Addr(s_b_addr), .B_En(s_b_en), .B_Data(s_b_data),
    .C_Addr(s_c_addr), .C_Data(s_c_data), .C_We(s_c_we),
    .Busy(s_busy), .Done(s_done), .SAD_Out(s_sad_out),
    .Min_Idx(s_min_idx));

  always @(posedge clk) begin
    if (s_a_en) s_a_data <= (s_a_addr < 4) ? 8'd255 : 8'd0;
    if (s_b_en) s_b_data <= 8'd0;
  end

  int npass = 0;
  int ntotal = 0;

  int          wr_addr [$];
  longint      wr_data [$];
  int          s_wr_cnt = 0;
  int          s_wr_val = -1;
  always @(negedge clk) begin
    if (c_we) begin
      wr_addr.push_back(int'(c_addr));
      wr_data.push_back(longint'(c_data));
    end
    if (s_c_we) begin
      s_wr_cnt++;
      s_wr_val = int'(s_c_data);
    end
  end

  longint exp_sad [NC];
  longint exp_min;
  int     exp_idx;

  task automatic compute_model();
    longint cap;
    cap = (64'd1 << SW) - 1;
    exp_min = -1;
    exp_idx = 0;
    for (int k = 0; k < NC; k++) begin
      longint s;
      s = 0;
      for (int i = 0; i < BL; i++) begin
        int d;
        d = int'(a_mem[i]) - int'(b_mem[k*BL+i]);
        s += (d < 0) ? -d : d;
      end
      exp_sad[k] = (s > cap) ? cap : s;
      if (k == 0 || exp_sad[k] < exp_min) begin
        exp_min = exp_sad[k];
        exp_idx = k;
      end
    end
  endtask

  task automatic run_main(input bit repulse, output int done_cyc,
                          output int busy_bad);
    done_cyc = 0;
    busy_bad = 0;
    wr_addr.delete();
    wr_data.delete();
    @(negedge clk);
    go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (repulse) go = (c == 2 || c == 10);
      if (!busy) busy_bad++;
      if (done) begin
        done_cyc = c;
        break;
      end
    end
    go = 1'b0;
  endtask

  task automatic load_example();
    for (int i = 0; i < BL; i++) a_mem[i] = 8'd5;
    for (int i = 0; i < BL; i++) begin
      b_mem[i]      = (i == 3) ? 8'd9 : 8'd5;
      b_mem[BL+i]   = 8'd5;
      b_mem[2*BL+i] = 8'd0;
    end
  endtask

  task automatic test_reset();
    #1;
    ntotal++;
    if ({busy, done, a_en, b_en, c_we} !== 5'b0) $display("FAIL reset_ctl: got %b want 00000", {busy, done, a_en, b_en, c_we});
    else npass++;
    ntotal++;
    if (a_addr !== '0 || b_addr !== '0 || c_addr !== '0) $display("FAIL reset_addr: got %0d/%0d/%0d want 0", a_addr, b_addr, c_addr);
    else npass++;
    ntotal++;
    if (c_data !== '0 || sad_out !== '0 || min_idx !== '0) $display("FAIL reset_data: got %0d/%0d/%0d want 0", c_data, sad_out, min_idx);
    else npass++;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_example();
    int dc, bb;
    longint want [3] = '{4, 0, 20};
    load_example();
    run_main(1'b0, dc, bb);
    ntotal++;
    if (dc !== 19) $display("FAIL ex_done_cycle: got %0d want 19", dc);
    else npass++;
    ntotal++;
    if (bb !== 0) $display("FAIL ex_busy: got %0d low cycles want 0", bb);
    else npass++;
    ntotal++;
    if (wr_addr.size() !== 3) $display("FAIL ex_wr_count: got %0d want 3", wr_addr.size());
    else npass++;
    for (int k = 0; k < 3; k++) begin
      ntotal++;
      if (wr_addr.size() <= k) $display("FAIL ex_wr%0d: got none want (%0d,%0d)", k, k, want[k]);
      else if (wr_addr[k] !== k || wr_data[k] !== want[k]) $display("FAIL ex_wr%0d: got (%0d,%0d) want (%0d,%0d)", k, wr_addr[k], wr_data[k], k, want[k]);
      else npass++;
    end
    ntotal++;
    if (sad_out !== 0 || min_idx !== 1) $display("FAIL ex_min: got %0d@%0d want 0@1", sad_out, min_idx);
    else npass++;
    @(negedge clk);
    ntotal++;
    if (done !== 1'b0 || busy !== 1'b0) $display("FAIL ex_done_pulse: got done=%b busy=%b want 0 0", done, busy);
    else npass++;
  endtask

  task automatic test_tie();
    int dc, bb;
    for (int i = 0; i < BL; i++) begin
      a_mem[i] = 8'd5;
      b_mem[i] = (i == 3) ? 8'd8 : 8'd5;
      b_mem[BL+i] = (i == 3) ? 8'd12 : 8'd5;
      b_mem[2*BL+i] = (i == 0) ? 8'd2 : 8'd5;
    end
    run_main(1'b0, dc, bb);
    ntotal++;
    if (sad_out !== 3 || min_idx !== 0) $display("FAIL tie_min: got %0d@%0d want 3@0", sad_out, min_idx);
    else npass++;
    // Outputs hold while idle even if memories change
    for (int i = 0; i < BL; i++) a_mem[i] = 8'd200;
    repeat (6) @(negedge clk);
    ntotal++;
    if (sad_out !== 3 || min_idx !== 0) $display("FAIL tie_hold: got %0d@%0d want 3@0", sad_out, min_idx);
    else npass++;
  endtask

  task automatic test_random();
    int dc, bb;
    for (int it = 0; it < 8; it++) begin
      int hi;
      hi = (it % 2 == 0) ? 255 : 3;
      for (int i = 0; i < BL; i++) a_mem[i] = 8'($urandom_range(0, hi));
      for (int i = 0; i < BL*NC; i++) b_mem[i] = 8'($urandom_range(0, hi));
      compute_model();
      run_main(1'b0, dc, bb);
      ntotal++;
      if (dc !== 19 || bb !== 0) $display("FAIL rnd%0d_timing: got done=%0d busylow=%0d want 19 0", it, dc, bb);
      else npass++;
      for (int k = 0; k < NC; k++) begin
        ntotal++;
        if (wr_addr.size() <= k) $display("FAIL rnd%0d_wr%0d: got none want %0d", it, k, exp_sad[k]);
        else if (wr_addr[k] !== k || wr_data[k] !== exp_sad[k]) $display("FAIL rnd%0d_wr%0d: got (%0d,%0d) want (%0d,%0d)", it, k, wr_addr[k], wr_data[k], k, exp_sad[k]);
        else npass++;
      end
      ntotal++;
      if (longint'(sad_out) !== exp_min || int'(min_idx) !== exp_idx) $display("FAIL rnd%0d_min: got %0d@%0d want %0d@%0d", it, sad_out, min_idx, exp_min, exp_idx);
      else npass++;
    end
  endtask

  task automatic test_repulse();
    int dc, bb;
    load_example();
    run_main(1'b1, dc, bb);
    ntotal++;
    if (dc !== 19) $display("FAIL repulse_done: got %0d want 19", dc);
    else npass++;
    ntotal++;
    if (wr_addr.size() !== 3) $display("FAIL repulse_wr_count: got %0d want 3", wr_addr.size());
    else npass++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int d1, d2, nw;
    load_example();
    d1 = 0;
    d2 = 0;
    wr_addr.delete();
    wr_data.delete();
    @(negedge clk);
    go = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (done && d1 == 0) d1 = c;
      else if (done) begin
        d2 = c;
        break;
      end
    end
    go = 1'b0;
    nw = wr_addr.size();
    ntotal++;
    if (d1 !== 19 || d2 !== 39) $display("FAIL b2b_done: got %0d,%0d want 19,39", d1, d2);
    else npass++;
    ntotal++;
    if (nw !== 6) $display("FAIL b2b_wr_count: got %0d want 6", nw);
    else npass++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int dc, bb, nd;
    load_example();
    wr_addr.delete();
    wr_data.delete();
    ntotal++;
    if (sad_out === 0) $display("FAIL rm_precond: got sad_out 0 want nonzero from prior run");
    else npass++;
    @(negedge clk);
    go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
    for (int c = 1; c <= 8; c++) @(negedge clk);
    rst = 1'b1;
    #1;
    ntotal++;
    if (busy !== 1'b0 || a_en !== 1'b0 || c_we !== 1'b0) $display("FAIL rm_abort: got busy=%b a_en=%b c_we=%b want 0", busy, a_en, c_we);
    else npass++;
    ntotal++;
    if (sad_out !== 0 || min_idx !== 0) $display("FAIL rm_sad: got %0d@%0d want 0@0", sad_out, min_idx);
    else npass++;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    nd = 0;
    repeat (25) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    ntotal++;
    if (wr_addr.size() !== 1 || nd !== 0) $display("FAIL rm_no_resume: got writes=%0d active=%0d want 1 0", wr_addr.size(), nd);
    else npass++;
    run_main(1'b0, dc, bb);
    ntotal++;
    if (dc !== 19 || wr_addr.size() !== 3) $display("FAIL rm_rerun: got done=%0d writes=%0d want 19 3", dc, wr_addr.size());
    else npass++;
    ntotal++;
    if (wr_addr.size() < 3) $display("FAIL rm_rerun_data: got %0d writes want 3", wr_addr.size());
    else if (wr_data[0] !== 4 || wr_data[1] !== 0 || wr_data[2] !== 20) $display("FAIL rm_rerun_data: got %0d,%0d,%0d want 4,0,20", wr_data[0], wr_data[1], wr_data[2]);
    else npass++;
    ntotal++;
    if (sad_out !== 0 || min_idx !== 1) $display("FAIL rm_rerun_min: got %0d@%0d want 0@1", sad_out, min_idx);
    else npass++;
  endtask

  task automatic test_saturation();
    int dc;
    dc = 0;
    s_wr_cnt = 0;
    @(negedge clk);
    s_go = 1'b1;
    @(posedge clk);
    #1 s_go = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (s_done) begin
        dc = c;
        break;
      end
    end
    ntotal++;
    if (dc !== 7) $display("FAIL sat_done: got %0d want 7", dc);
    else npass++;
    ntotal++;
    if (s_wr_cnt !== 1 || s_wr_val !== 15) $display("FAIL sat_cdata: got n=%0d val=%0d want 1 15", s_wr_cnt, s_wr_val);
    else npass++;
    ntotal++;
    if (s_sad_out !== 4'd15 || s_min_idx !== 1'b0) $display("FAIL sat_out: got %0d@%0d want 15@0", s_sad_out, s_min_idx);
    else npass++;
  endtask

  initial begin
    test_reset();
    test_example();
    test_tie();
    test_reset_mid();
    test_random();
    test_repulse();
    test_back_to_back();
    test_saturation();
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/sad_search.md
SAD_SEARCH -- requirements
Module: sad_search

Interface
REQ-001 SHALL have parameter D_WIDTH, default 8, pixel width in bits.
REQ-002 SHALL have parameter A_WIDTH, default 15, memory address width.
REQ-003 SHALL have parameter BLK_LEN, default 256, elements per block, >=1.
REQ-004 SHALL have parameter NUM_CAND, default 4, number of candidate blocks, >=1; NUM_CAND*BLK_LEN <= 2^A_WIDTH.
REQ-005 SHALL have parameter SAD_WIDTH, default 32, accumulator and result width.
REQ-006 SHALL have derived parameter IDX_W = max(1, clog2(NUM_CAND)).
REQ-007 Clk  in  1  single clock, all state on rising edge.
REQ-008 Rst  in  1  reset, asynchronous, active-high.
REQ-009 Go  in  1  start request, sampled in IDLE only.
REQ-010 A_Addr  out  A_WIDTH  reference-block read address.
REQ-011 A_En  out  1  reference memory read enable.
REQ-012 A_Data  in  D_WIDTH  reference read data, valid one cycle after A_En/A_Addr.
REQ-013 B_Addr  out  A_WIDTH  candidate read address.
REQ-014 B_En  out  1  candidate memory read enable.
REQ-015 B_Data  in  D_WIDTH  candidate read data, valid one cycle after B_En/B_Addr.
REQ-016 C_Addr  out  IDX_W  result memory write address (candidate index).
REQ-017 C_Data  out  SAD_WIDTH  per-candidate SAD write data.
REQ-018 C_We  out  1  result write strobe, one cycle per candidate.
REQ-019 Busy  out  1  high in every state except IDLE.
REQ-020 Done  out  1  one-cycle completion pulse.
REQ-021 SAD_Out  out  SAD_WIDTH  minimum SAD of last completed run.
REQ-022 Min_Idx  out  IDX_W  candidate index of SAD_Out.

Function
REQ-023 SHALL implement FSM states IDLE, READ, DRAIN, STORE, DONE.
REQ-024 IDLE: Go=1 at rising edge -> READ, candidate k=0, element i=0, accumulator 0, running min = all-ones, Min_Idx candidate 0.
REQ-025 READ: one cycle per element i=0..BLK_LEN-1; A_En=B_En=1, A_Addr=i, B_Addr=k*BLK_LEN+i; after i=BLK_LEN-1 -> DRAIN.
REQ-026 Each cycle after a valid read (READ cycles i>=1 and DRAIN) SHALL add |A_Data-B_Data| (unsigned D_WIDTH operands, D_WIDTH-bit magnitude) to the accumulator.
REQ-027 Accumulator SHALL saturate at 2^SAD_WIDTH-1; no wrap-around.
REQ-028 DRAIN -> STORE; A_En=B_En=0 in DRAIN, STORE, DONE, IDLE.
REQ-029 STORE: C_We=1, C_Addr=k, C_Data=final accumulator for candidate k.
REQ-030 STORE: if sum < running min (strict), running min<=sum and index<=k; ties keep the lower index.
REQ-031 STORE: k<NUM_CAND-1 -> READ with k+1, i=0, accumulator cleared; else -> DONE.
REQ-032 DONE: Done=1 for exactly one cycle; SAD_Out/Min_Idx updated at the edge that enters DONE; -> IDLE.
REQ-033 Latency: Done high in cycle NUM_CAND*(BLK_LEN+2)+1 counted from the Go-sampling edge (cycle 1 = first READ cycle).
REQ-034 Go while Busy=1 SHALL be ignored; Go held high at DONE->IDLE starts a new run on the next edge.
REQ-035 SAD_Out and Min_Idx SHALL hold their values from the last completed run until the next DONE.

Reset
REQ-036 Rst=1 SHALL immediately force IDLE, accumulator and running min cleared, A_En=B_En=C_We=Busy=Done=0, all addresses 0, C_Data=0, SAD_Out=0, Min_Idx=0.
REQ-037 Rst asserted mid-run SHALL abort without further C_We and without updating SAD_Out/Min_Idx; the aborted run is not resumed.

Verification
REQ-038 BLK_LEN=4, NUM_CAND=3; A={5,5,5,5}; B cand0={5,5,5,9}, cand1={5,5,5,5}, cand2={0,0,0,0}; Go pulse -> C writes (0,4),(1,0),(2,20), SAD_Out=0, Min_Idx=1, Done in cycle 19.
REQ-039 Tie: cand0=cand2=SAD 3, cand1=SAD 7 -> SAD_Out=3, Min_Idx=0.
REQ-040 Saturation: SAD_WIDTH=4, BLK_LEN=4, NUM_CAND=1, A all 255, B all 0 -> C_Data=15, SAD_Out=15.
REQ-041 Go re-pulsed in cycles 2 and 10 of a run -> no restart; Done still in cycle 19; C_We count 3.
REQ-042 Rst in cycle 8 of REQ-038 run -> Busy=0 immediately, no further C_We, SAD_Out=0; fresh Go afterwards reproduces REQ-038 results.
